// File: rtl/accel_regmap_pkg.sv
// Shared CSR word map, status/IRQ bit positions and job-state encoding for the
// host register map.
package accel_regmap_pkg;

  localparam logic [1:0] CSR_STATUS    = 2'd0;
  localparam logic [1:0] CSR_CTRL      = 2'd1;
  localparam logic [1:0] CSR_FRAME_CNT = 2'd2;
  localparam logic [1:0] CSR_IRQ_CTRL  = 2'd3;
  localparam int unsigned CSR_BYTES    = 16;

  localparam int STAT_RST_BIT  = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_DONE_BIT = 2;
  localparam int IRQ_EN_BIT    = 0;
  localparam int IRQ_PEND_BIT  = 1;

  typedef enum logic [1:0] {
    JOB_IDLE = 2'd0,
    JOB_BUSY = 2'd1,
    JOB_DONE = 2'd2
  } job_state_e;

  // Half-open [base, base+size); an address below base wraps large and misses.
  function automatic logic in_range(logic [31:0] a, int unsigned base, int unsigned size);
    return (a - base) < size;
  endfunction

endpackage

// File: rtl/axi_host_regmap_if.sv
// AXI-lite-style word write / 1-cycle read bus between host and register map.
interface axi_host_regmap_if #(parameter int ADDR_W = 20) ();
  logic [31:0]       wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_strobe;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              rd_valid;

  modport master (output wr_data, wr_addr, wr_strobe, wr_en, rd_addr, rd_en,
                  input  rd_data, rd_valid);
  modport slave  (input  wr_data, wr_addr, wr_strobe, wr_en, rd_addr, rd_en,
                  output rd_data, rd_valid);
endinterface

// File: rtl/axi_host_regmap_soft_reset_gen.sv
// Stretched soft reset: a start pulse holds core_rst_n low for RST_CYCLES
// cycles beginning the cycle after; restarts while running are ignored.
module soft_reset_gen #(
  parameter int RST_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic busy_o,
  output logic core_rst_n_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt_q <= '0;
    else if (cnt_q != '0)  cnt_q <= cnt_q - 8'd1;
    else if (start_i)      cnt_q <= 8'(RST_CYCLES);
  end

  assign busy_o       = (cnt_q != '0);
  assign core_rst_n_o = rst_n & ~busy_o;

endmodule

// File: rtl/axi_host_regmap.sv
// Host register map / address decoder for the lane-detection accelerator.
// Optional interrupt logic is built when HOST_IF_IRQ_EN is defined.
module axi_host_regmap
  import accel_regmap_pkg::*;
#(
  parameter int ADDR_W       = 20,
  parameter int OFF_INPUT    = 0,
  parameter int IN_BYTES     = 393216,
  parameter int OFF_OUTPUT   = 393216,
  parameter int OUT_BYTES    = 2048,
  parameter int OFF_CSR      = 395264,
  parameter int OFF_WEIGHT   = 395300,
  parameter int WEIGHT_BYTES = 153952,
  parameter int RST_CYCLES   = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axi_host_regmap_if.slave               axi,
  output logic                           core_rst_n,
  output logic                           in_wr_en,
  output logic                           wt_wr_en,
  output logic [ADDR_W-1:0]              region_addr,
  output logic                           out_rd_en,
  output logic [$clog2(OUT_BYTES)-3:0]   out_rd_addr,
  input  logic [31:0]                    out_rd_data,
  input  logic                           core_first_px,
  input  logic                           core_done,
  output logic                           irq
);

  localparam int OUT_AW = $clog2(OUT_BYTES) - 2;

  logic [31:0] wa, ra;
  logic        csr_wr_hit, csr_rd_hit, srst_start, srst_busy;
  logic [1:0]  wr_idx, rd_idx;
  logic [31:0] status, irq_ctrl_rd, rd_word_d, rd_data_q;
  logic        rd_valid_q, rd_sel_out_q;
  logic [31:0] frame_cnt_q;
  job_state_e  state_q;
  logic        unused_bits;

  assign wa = 32'(axi.wr_addr);
  assign ra = 32'(axi.rd_addr);

  // Region write decode is purely combinational so the RAM write lands this cycle.
  always_comb begin
    in_wr_en    = 1'b0;
    wt_wr_en    = 1'b0;
    region_addr = '0;
    if (axi.wr_en && in_range(wa, OFF_INPUT, IN_BYTES)) begin
      in_wr_en    = 1'b1;
      region_addr = ADDR_W'(wa - 32'(OFF_INPUT));
    end else if (axi.wr_en && in_range(wa, OFF_WEIGHT, WEIGHT_BYTES)) begin
      wt_wr_en    = 1'b1;
      region_addr = ADDR_W'(wa - 32'(OFF_WEIGHT));
    end
  end

  assign csr_wr_hit = axi.wr_en && in_range(wa, OFF_CSR, CSR_BYTES);
  assign wr_idx     = 2'((wa - 32'(OFF_CSR)) >> 2);
  assign srst_start = csr_wr_hit && (wr_idx == CSR_CTRL) && axi.wr_strobe[0] && axi.wr_data[0];

  soft_reset_gen #(.RST_CYCLES(RST_CYCLES)) u_srst (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (srst_start),
    .busy_o       (srst_busy),
    .core_rst_n_o (core_rst_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= JOB_IDLE;
      frame_cnt_q <= '0;
    end else if (srst_busy) begin
      state_q     <= JOB_IDLE;
    end else begin
      case (state_q)
        JOB_IDLE, JOB_DONE: if (core_first_px) state_q <= JOB_BUSY;
        JOB_BUSY: if (core_done) begin
          state_q     <= JOB_DONE;
          frame_cnt_q <= frame_cnt_q + 32'd1;
        end
        default: state_q <= JOB_IDLE;
      endcase
    end
  end

`ifdef HOST_IF_IRQ_EN
  logic irq_en_q, irq_en_d, irq_pend_q, irq_pend_d, irq_q, done_evt;

  assign done_evt = ~srst_busy & (state_q == JOB_BUSY) & core_done;

  // A completion in the same cycle as a W1C keeps the interrupt pending.
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (csr_wr_hit && (wr_idx == CSR_IRQ_CTRL) && axi.wr_strobe[0]) begin
      irq_en_d = axi.wr_data[IRQ_EN_BIT];
      if (axi.wr_data[IRQ_PEND_BIT]) irq_pend_d = 1'b0;
    end
    if (done_evt) irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_en_d & irq_pend_d;
    end
  end

  always_comb begin
    irq_ctrl_rd               = '0;
    irq_ctrl_rd[IRQ_EN_BIT]   = irq_en_q;
    irq_ctrl_rd[IRQ_PEND_BIT] = irq_pend_q;
  end
  assign irq = irq_q;
`else
  assign irq_ctrl_rd = '0;
  assign irq         = 1'b0;
`endif

  always_comb begin
    status                = '0;
    status[STAT_RST_BIT]  = core_rst_n;
    status[STAT_BUSY_BIT] = (state_q == JOB_BUSY);
    status[STAT_DONE_BIT] = (state_q == JOB_DONE);
  end

  assign out_rd_en   = axi.rd_en && in_range(ra, OFF_OUTPUT, OUT_BYTES);
  assign out_rd_addr = OUT_AW'((ra - 32'(OFF_OUTPUT)) >> 2);
  assign csr_rd_hit  = in_range(ra, OFF_CSR, CSR_BYTES);
  assign rd_idx      = 2'((ra - 32'(OFF_CSR)) >> 2);

  // CSR reads sample the _q registers, so a same-cycle write is not yet visible.
  always_comb begin
    rd_word_d = '0;
    if (csr_rd_hit) begin
      case (rd_idx)
        CSR_STATUS:    rd_word_d = status;
        CSR_FRAME_CNT: rd_word_d = frame_cnt_q;
        CSR_IRQ_CTRL:  rd_word_d = irq_ctrl_rd;
        default:       rd_word_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q   <= 1'b0;
      rd_sel_out_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      rd_valid_q   <= axi.rd_en;
      rd_sel_out_q <= out_rd_en;
      rd_data_q    <= axi.rd_en ? rd_word_d : '0;
    end
  end

  assign axi.rd_valid = rd_valid_q;
  assign axi.rd_data  = rd_sel_out_q ? out_rd_data : rd_data_q;

  assign unused_bits = ^{axi.wr_data[31:1], axi.wr_strobe[3:1]};

endmodule

// File: tb/tb_axi_host_regmap.sv
// Randomized bench for axi_host_regmap with a behavioural register-map model;
// irq checks follow HOST_IF_IRQ_EN.
module tb_axi_host_regmap;

  localparam int ADDR_W = 20, OFF_INPUT = 0, IN_BYTES = 393216, OFF_OUTPUT = 393216;
  localparam int OUT_BYTES = 2048, OFF_CSR = 395264, OFF_WEIGHT = 395300;
  localparam int WEIGHT_BYTES = 153952, RST_CYCLES = 15;

  logic clk, rst_n, core_rst_n, in_wr_en, wt_wr_en, out_rd_en, irq;
  logic core_first_px, core_done;
  logic [ADDR_W-1:0] region_addr;
  logic [8:0]        out_rd_addr;
  logic [31:0]       out_rd_data;
  logic [31:0]       mem [512];

  int n_tests = 0, n_fail = 0;
  logic chk_on = 1'b0;

  axi_host_regmap_if #(.ADDR_W(ADDR_W)) axi ();

  axi_host_regmap dut (
    .clk(clk), .rst_n(rst_n), .axi(axi), .core_rst_n(core_rst_n),
    .in_wr_en(in_wr_en), .wt_wr_en(wt_wr_en), .region_addr(region_addr),
    .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
    .core_first_px(core_first_px), .core_done(core_done), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output RAM stand-in with one cycle of read latency.
  always @(posedge clk) if (out_rd_en) out_rd_data <= mem[out_rd_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state;   // 0 idle, 1 busy, 2 done
  int          m_cnt;     // soft-reset cycles still to run
  logic [31:0] m_frames, m_rdd;
  logic        m_rdv, m_en, m_pend, m_irq;
  int          wa_i, ra_i;
  logic        m_ctrl, m_irqwr, m_done_ev, m_en_n, m_pend_n;

  assign wa_i      = int'(axi.wr_addr);
  assign ra_i      = int'(axi.rd_addr);
  assign m_ctrl    = axi.wr_en && wa_i >= OFF_CSR + 4 && wa_i < OFF_CSR + 8 &&
                     axi.wr_strobe[0] && axi.wr_data[0];
  assign m_irqwr   = axi.wr_en && wa_i >= OFF_CSR + 12 && wa_i < OFF_CSR + 16 && axi.wr_strobe[0];
  assign m_done_ev = (m_cnt == 0) && (m_state == 1) && core_done;
  assign m_en_n    = m_irqwr ? axi.wr_data[0] : m_en;
  assign m_pend_n  = m_done_ev ? 1'b1 : (m_irqwr && axi.wr_data[1]) ? 1'b0 : m_pend;

  function automatic logic [31:0] exp_read(input int a);
    logic [31:0] v = 32'd0;
    if (a >= OFF_OUTPUT && a < OFF_OUTPUT + OUT_BYTES) v = mem[(a - OFF_OUTPUT) >> 2];
    else if (a >= OFF_CSR && a < OFF_CSR + 16) begin
      case ((a - OFF_CSR) / 4)
        0: v = {29'd0, m_state == 2, m_state == 1, m_cnt == 0};
        2: v = m_frames;
`ifdef HOST_IF_IRQ_EN
        3: v = {30'd0, m_pend, m_en};
`endif
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_cnt <= 0; m_frames <= 0; m_rdv <= 0; m_rdd <= 0;
      m_en <= 0; m_pend <= 0; m_irq <= 0;
    end else begin
      m_rdv <= axi.rd_en;
      m_rdd <= axi.rd_en ? exp_read(ra_i) : 32'd0;
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
      else if (m_ctrl) m_cnt <= RST_CYCLES;
      if (m_cnt > 0) m_state <= 0;
      else if (m_state != 1 && core_first_px) m_state <= 1;
      else if (m_state == 1 && core_done) begin
        m_state <= 2; m_frames <= m_frames + 1;
      end
`ifdef HOST_IF_IRQ_EN
      m_en <= m_en_n; m_pend <= m_pend_n; m_irq <= m_en_n & m_pend_n;
`endif
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      logic e_in, e_wt;
      e_in = axi.wr_en && wa_i >= OFF_INPUT && wa_i < OFF_INPUT + IN_BYTES;
      e_wt = axi.wr_en && wa_i >= OFF_WEIGHT && wa_i < OFF_WEIGHT + WEIGHT_BYTES;
      chk("cyc_core_rst_n", 32'(core_rst_n), 32'(m_cnt == 0));
      chk("cyc_in_wr_en", 32'(in_wr_en), 32'(e_in));
      chk("cyc_wt_wr_en", 32'(wt_wr_en), 32'(e_wt));
      if (e_in) chk("cyc_region_in", 32'(region_addr), 32'(wa_i - OFF_INPUT));
      if (e_wt) chk("cyc_region_wt", 32'(region_addr), 32'(wa_i - OFF_WEIGHT));
      chk("cyc_out_rd_en", 32'(out_rd_en),
          32'(axi.rd_en && ra_i >= OFF_OUTPUT && ra_i < OFF_OUTPUT + OUT_BYTES));
      if (out_rd_en) chk("cyc_out_rd_addr", 32'(out_rd_addr), 32'((ra_i - OFF_OUTPUT) >> 2));
      chk("cyc_rd_valid", 32'(axi.rd_valid), 32'(m_rdv));
      if (axi.rd_valid) chk("cyc_rd_data", axi.rd_data, m_rdd);
      chk("cyc_irq", 32'(irq), 32'(m_irq));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    axi.wr_en = 0; axi.rd_en = 0; core_first_px = 0; core_done = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    axi.wr_en = 1; axi.wr_addr = ADDR_W'(a); axi.wr_data = d; axi.wr_strobe = 4'hF;
    step(); axi.wr_en = 0;
  endtask

  task automatic rd_lit(input string nm, input int a, input logic [31:0] exp);
    axi.rd_en = 1; axi.rd_addr = ADDR_W'(a);
    step(); axi.rd_en = 0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(axi.rd_valid), 32'd1);
    chk(nm, axi.rd_data, exp);
    #1;
  endtask

  function automatic int rand_addr();
    int w;
    case ($urandom_range(0, 7))
      0: return 4 * $urandom_range(0, IN_BYTES / 4 - 1);
      1: return IN_BYTES - 4 + 4 * $urandom_range(0, 1);
      2: return OFF_OUTPUT + 4 * $urandom_range(0, OUT_BYTES / 4 - 1);
      3: return OFF_WEIGHT + 4 * $urandom_range(0, WEIGHT_BYTES / 4 - 1);
      4: return OFF_WEIGHT + WEIGHT_BYTES - 4 + 4 * $urandom_range(0, 1);
      5, 6: begin
        w = $urandom_range(0, 8);
        if (w == 1 && $urandom_range(0, 9) != 0) w = 0;
        return OFF_CSR + 4 * w;
      end
      default: return int'($urandom_range(0, (1 << ADDR_W) - 1));
    endcase
  endfunction

  initial begin
    int lo;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    rst_n = 0; idle(); axi.wr_addr = '0; axi.wr_data = '0; axi.wr_strobe = '0; axi.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_rd_data", axi.rd_data, 32'd0);
    chk("rst_rd_valid", 32'(axi.rd_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    #1 chk_on = 1;
    rd_lit("rst_status", OFF_CSR, 32'h1);

    // Soft reset stretch, with a second CTRL write that must not extend it.
    step(); wr(OFF_CSR + 4, 32'h1);
    lo = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) begin
        axi.wr_en = 1; axi.wr_addr = ADDR_W'(OFF_CSR + 4); axi.wr_data = 32'h1;
      end else axi.wr_en = 0;
      @(negedge clk);
      if (!core_rst_n) lo++;
      step();
    end
    axi.wr_en = 0;
    chk("srst_len", 32'(lo), 32'd15);

    // Job FSM: done twice counts one frame.
    core_first_px = 1; step(); core_first_px = 0;
    core_done = 1; step(); step(); core_done = 0;
    rd_lit("fsm_status", OFF_CSR, 32'h5);
    rd_lit("fsm_frames", OFF_CSR + 8, 32'd1);

    // Weight-region decode and its upper boundary.
    axi.wr_en = 1; axi.wr_addr = ADDR_W'(OFF_WEIGHT + 8); axi.wr_data = 32'hA5;
    @(negedge clk);
    chk("wt_hit", 32'(wt_wr_en), 32'd1);
    chk("wt_region", 32'(region_addr), 32'd8);
    step(); axi.wr_addr = ADDR_W'(OFF_WEIGHT + WEIGHT_BYTES);
    @(negedge clk);
    chk("wt_end_wt", 32'(wt_wr_en), 32'd0);
    chk("wt_end_in", 32'(in_wr_en), 32'd0);
    step(); axi.wr_en = 0;

    // Back-to-back output-RAM reads.
    axi.rd_en = 1; axi.rd_addr = ADDR_W'(OFF_OUTPUT);
    @(negedge clk); chk("b2b_addr0", 32'(out_rd_addr), 32'd0);
    step(); axi.rd_addr = ADDR_W'(OFF_OUTPUT + 4);
    @(negedge clk); chk("b2b_addr1", 32'(out_rd_addr), 32'd1);
    chk("b2b_data0", axi.rd_data, mem[0]);
    step(); axi.rd_addr = ADDR_W'(OFF_OUTPUT + 2044);
    @(negedge clk); chk("b2b_addr2", 32'(out_rd_addr), 32'd511);
    chk("b2b_data1", axi.rd_data, mem[1]);
    step(); axi.rd_en = 0;
    @(negedge clk); chk("b2b_valid2", 32'(axi.rd_valid), 32'd1);
    chk("b2b_data2", axi.rd_data, mem[511]);
    #1;

`ifdef HOST_IF_IRQ_EN
    wr(OFF_CSR + 12, 32'h1);
    core_first_px = 1; step(); core_first_px = 0;
    core_done = 1; step(); core_done = 0;
    @(negedge clk); chk("irq_set", 32'(irq), 32'd1);
    #1 core_first_px = 1; step(); core_first_px = 0;
    core_done = 1; axi.wr_en = 1; axi.wr_addr = ADDR_W'(OFF_CSR + 12); axi.wr_data = 32'h3;
    step(); core_done = 0; axi.wr_en = 0;
    @(negedge clk); chk("irq_set_wins", 32'(irq), 32'd1);
    #1 wr(OFF_CSR + 12, 32'h3);
    @(negedge clk); chk("irq_w1c", 32'(irq), 32'd0);
    #1;
`endif

    for (int i = 0; i < 4000; i++) begin
      axi.wr_en     = ($urandom_range(0, 1) == 1);
      axi.wr_addr   = ADDR_W'(rand_addr());
      axi.wr_data   = $urandom;
      axi.wr_strobe = 4'($urandom);
      axi.rd_en     = ($urandom_range(0, 1) == 1);
      axi.rd_addr   = ADDR_W'(rand_addr());
      core_first_px = ($urandom_range(0, 7) == 0);
      core_done     = ($urandom_range(0, 5) == 0);
      step();
    end
    idle(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
